// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: operation-select encodings.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_bit_cnt.sv
// Counts shifts within a WIDTH-long frame and pulses done on the wrapping edge.
module shift_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_done;

    // done defaults low every edge so the pulse never outlives one cycle, even with en low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
            end else if (inc) begin
                if (r_cnt == LAST) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign done = r_done;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift-left / shift-right / parallel load.
// Define SHIFT_CNT_EN to add the frame counter and the frame_done output.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r
`ifdef SHIFT_CNT_EN
    ,
    output logic             frame_done
`endif
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sin};
                MODE_SHR:  r_q <= {sin, r_q[WIDTH-1:1]};
                MODE_LOAD: r_q <= d;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

`ifdef SHIFT_CNT_EN
    logic w_inc;
    logic w_clr;

    assign w_inc = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
    assign w_clr = en && (mode == MODE_LOAD);

    shift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_inc),
        .clr  (w_clr),
        .done (frame_done)
    );
`endif

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter: WIDTH, 8, register length in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  input  1  clock enable; 0 freezes all state.
REQ-005 SHALL have port: mode  input  2  operation select; encoding per REQ-010.
REQ-006 SHALL have port: sin  input  1  serial data in.
REQ-007 SHALL have port: d  input  WIDTH  parallel load data.
REQ-008 SHALL have ports: q  output  WIDTH  register contents; sout_l  output  1  = q[WIDTH-1]; sout_r  output  1  = q[0].
REQ-009 SHALL have port (only with SHIFT_CNT_EN): frame_done  output  1  one-cycle pulse after WIDTH shifts.

Function
REQ-010 SHALL decode mode on a rising edge with en=1 as: 00 HOLD (q unchanged); 01 SHL (q <= {q[WIDTH-2:0], sin}); 10 SHR (q <= {sin, q[WIDTH-1:1]}); 11 LOAD (q <= d).
REQ-011 SHALL leave q, the shift counter and mode-independent state unchanged on any edge with en=0.
REQ-012 SHALL drive sout_l and sout_r combinationally from q, with no added latency.
REQ-013 SHALL give LOAD and shift operations single-cycle latency: the new q is visible immediately after the edge.
REQ-014 SHALL, with SHIFT_CNT_EN, keep a shift counter cnt (0..WIDTH-1, width $clog2(WIDTH)), incremented on each enabled SHL or SHR edge.
REQ-015 SHALL wrap cnt from WIDTH-1 to 0 on the WIDTH-th shift; on that same edge it SHALL set frame_done=1.
REQ-016 SHALL clear frame_done on the following edge regardless of en, so the pulse lasts exactly one cycle.
REQ-017 SHALL clear cnt to 0 on LOAD and hold cnt on HOLD; LOAD on the edge after a wrap SHALL NOT re-assert frame_done.
REQ-018 SHALL let SHL and SHR share one counter; a change of direction mid-frame SHALL NOT reset cnt.

Reset
REQ-019 SHALL, while rst=0, force q=0, cnt=0 and frame_done=0 immediately, independent of clk and en.
REQ-020 SHALL discard a partially counted frame if rst asserts mid-frame; the first enabled shift after release SHALL count as shift 1.
REQ-021 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-022 SHALL, with macro SHIFT_CNT_EN defined, include the counter, the frame_done port and REQ-014..REQ-018.
REQ-023 SHALL, with SHIFT_CNT_EN undefined, omit the counter logic and the frame_done port, leaving shift/load behaviour identical.

Structure
REQ-024 SHALL define the mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD) as named constants in package shift_reg_pkg.
REQ-025 SHALL implement the counter and frame_done generation in sub-module shift_bit_cnt (parameter WIDTH; inputs clk, rst, inc, clr; output done).

Verification (WIDTH=4, SHIFT_CNT_EN defined)
REQ-026 SHALL cover reset: rst=0 with q previously 1011 -> q=0000 and frame_done=0 before the next clk edge.
REQ-027 SHALL cover SHL: sin sequence 1,0,1,1 under SHL with en=1 -> q=1011 after the 4th edge, frame_done=1 for exactly one cycle.
REQ-028 SHALL cover SHR and serial out: LOAD d=1000, then SHR with sin=0 for 3 edges -> q=0001 and sout_r=1.
REQ-029 SHALL cover enable gating: after LOAD d=0110, hold en=0 with mode=SHL for 5 edges -> q=0110 and no frame_done.
REQ-030 SHALL cover counter clear: 2 SHL edges, then LOAD d=1111, then 4 SHL edges -> frame_done pulses only after the 4th post-LOAD shift.
REQ-031 SHALL cover reset mid-frame: 3 shifts, assert rst, release, then 4 shifts -> exactly one frame_done, on the 4th post-reset shift.
